// File: rtl/pulse_scan_ctrl_pkg.sv
// pulse_pkg: shared types and defaults for the pulse delay scan controller
// Contents: scan FSM state encoding, default delay width and settle count.
package pulse_pkg;
   typedef enum logic [1:0] {IDLE, ALIGN, RUN, DONE} state_t;
   localparam int DW_DEFAULT     = 16;
   localparam int SETTLE_DEFAULT = 1;
endpackage

// File: rtl/pulse_scan_ctrl_scan_counter.sv
// scan_counter: loadable up-counter with terminal-count compare
// Ports: clk; reset (async, active-high); ld/ld_val load a value (wins over inc);
//        inc counts up by one; term is the compare value; cnt is the count;
//        tc is high while cnt equals term.
module scan_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         inc,
   input  logic [W-1:0] term,
   output logic [W-1:0] cnt,
   output logic         tc
);
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else if (ld) cnt <= ld_val;
      else if (inc) cnt <= cnt + 1'b1;
   assign tc = cnt == term;
endmodule

// File: rtl/pulse_scan_ctrl.sv
// pulse_scan_ctrl: steps the pulse generator delay through a scan, N shots per point
// Ports: clk; reset (async, active-high);
//        cfg_valid/cfg_ready + cfg_start_del/cfg_step_del/cfg_points/cfg_shots: scan setup;
//        start/abort: 1-cycle scan control pulses; period_start: generator period strobe;
//        del_out/del_upd: delay to the generator and its change strobe;
//        shot_valid: one strobe per counted shot; point_idx: current point;
//        busy/done: scan status; err_ovf: sticky delay overflow flag.
module pulse_scan_ctrl
   import pulse_pkg::*;
#(
   parameter int DW     = DW_DEFAULT,
   parameter int SETTLE = SETTLE_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [DW-1:0] cfg_start_del,
   input  logic [DW-1:0] cfg_step_del,
   input  logic [DW-1:0] cfg_points,
   input  logic [DW-1:0] cfg_shots,
   input  logic          start,
   input  logic          abort,
   input  logic          period_start,
   output logic [DW-1:0] del_out,
   output logic          del_upd,
   output logic          shot_valid,
   output logic [DW-1:0] point_idx,
   output logic          busy,
   output logic          done,
   output logic          err_ovf
);
   localparam logic [3:0] SETTLE_N = 4'(SETTLE);
   state_t        state;
   logic [DW-1:0] sh_start, sh_step, sh_points, sh_shots, unused_shot_cnt;
   logic [3:0]    settle;
   logic [DW:0]   nxt;
   logic          shot_tc, pt_tc, go, pt_end, adv, shot_inc;
   assign cfg_ready = state == IDLE || state == DONE;
   // one cycle after the last shot of a point: either finish or advance the delay
   always_comb begin
      nxt      = {1'b0, del_out} + {1'b0, sh_step};
      go       = state == IDLE && start && sh_points != '0 && sh_shots != '0;
      pt_end   = state == RUN && !abort && shot_tc;
      adv      = pt_end && !pt_tc && !nxt[DW];
      shot_inc = state == RUN && !abort && !shot_tc && period_start;
   end
   scan_counter #(.W(DW)) u_shots (
      .clk(clk), .reset(reset), .ld(go || adv), .ld_val('0), .inc(shot_inc),
      .term(sh_shots), .cnt(unused_shot_cnt), .tc(shot_tc)
   );
   scan_counter #(.W(DW)) u_points (
      .clk(clk), .reset(reset), .ld(go), .ld_val('0), .inc(adv),
      .term(sh_points - 1'b1), .cnt(point_idx), .tc(pt_tc)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= IDLE;
         sh_start   <= '0;
         sh_step    <= '0;
         sh_points  <= '0;
         sh_shots   <= '0;
         settle     <= '0;
         del_out    <= '0;
         del_upd    <= 1'b0;
         shot_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err_ovf    <= 1'b0;
      end else begin
         del_upd    <= 1'b0;
         shot_valid <= 1'b0;
         done       <= 1'b0;
         if (cfg_valid && cfg_ready) begin
            sh_start  <= cfg_start_del;
            sh_step   <= cfg_step_del;
            sh_points <= cfg_points;
            sh_shots  <= cfg_shots;
            err_ovf   <= 1'b0;
         end
         case (state)
            IDLE:
               if (start) begin
                  if (go) begin
                     del_out <= sh_start;
                     del_upd <= 1'b1;
                     settle  <= SETTLE_N;
                     busy    <= 1'b1;
                     state   <= ALIGN;
                  end else state <= DONE;
               end
            ALIGN:
               if (abort) state <= DONE;
               else begin
                  // the strobe that finishes settling is discarded, not counted as a shot
                  if (period_start && settle != 4'd0) settle <= settle - 1'b1;
                  if (settle == 4'd0 || (period_start && settle == 4'd1)) state <= RUN;
               end
            RUN:
               if (abort) state <= DONE;
               else if (pt_end) begin
                  if (pt_tc) state <= DONE;
                  else if (nxt[DW]) begin
                     err_ovf <= 1'b1;
                     state   <= DONE;
                  end else begin
                     del_out <= nxt[DW-1:0];
                     del_upd <= 1'b1;
                     settle  <= SETTLE_N;
                     state   <= ALIGN;
                  end
               end else if (period_start) shot_valid <= 1'b1;
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_pulse_scan_ctrl.sv
// tb_pulse_scan_ctrl: scoreboard bench for the delay scan controller
module tb_pulse_scan_ctrl;
   logic        clk = 1'b0, reset = 1'b1;
   logic        cfg_valid = 1'b0, start = 1'b0, abort = 1'b0, period_start = 1'b0;
   logic [15:0] cfg_start_del = '0, cfg_step_del = '0, cfg_points = '0, cfg_shots = '0;
   logic        cfg_ready, del_upd, shot_valid, busy, done, err_ovf;
   logic [15:0] del_out, point_idx;
   typedef struct {logic [15:0] v; logic e; int per;} exp_t;
   exp_t q_upd[$], q_shot[$], q_done[$];
   int checks = 0, errors = 0, pcount = 0;
   pulse_scan_ctrl #(.DW(16), .SETTLE(1)) dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_start_del(cfg_start_del), .cfg_step_del(cfg_step_del),
      .cfg_points(cfg_points), .cfg_shots(cfg_shots), .start(start), .abort(abort),
      .period_start(period_start), .del_out(del_out), .del_upd(del_upd),
      .shot_valid(shot_valid), .point_idx(point_idx), .busy(busy), .done(done),
      .err_ovf(err_ovf)
   );
   always #10 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic miss(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: unexpected strobe (value %0h), expected none", name, act);
   endtask
   task automatic chk_empty(input string name);
      chk({name, "_queues"}, q_upd.size() + q_shot.size() + q_done.size(), 0);
   endtask
   task automatic cfg(input logic [15:0] s, input logic [15:0] st, input logic [15:0] p, input logic [15:0] n);
      cfg_start_del = s;
      cfg_step_del  = st;
      cfg_points    = p;
      cfg_shots     = n;
      cfg_valid     = 1'b1;
      tick();
      cfg_valid     = 1'b0;
   endtask
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask
   task automatic run_periods(input int k);
      for (int i = 0; i < k; i++) begin
         repeat (19) tick();
         period_start = 1'b1;
         pcount++;
         tick();
         period_start = 1'b0;
      end
   endtask
   task automatic wait_done(input string name, input int lim);
      int n = 0;
      while (!done && n < lim) begin
         tick();
         n++;
      end
      chk(name, 32'(done), 1);
   endtask
   // start=100 step=50 points=3 shots=4: one discarded period, then four shots per point
   task automatic sched_scan1();
      q_upd.push_back('{16'd100, 1'b0, 0});
      for (int p = 0; p < 3; p++) begin
         if (p > 0) q_upd.push_back('{16'(100 + 50 * p), 1'b0, 5 * p});
         for (int s = 0; s < 4; s++) q_shot.push_back('{16'(p), 1'b0, 5 * p + 2 + s});
      end
      q_done.push_back('{16'd200, 1'b0, 15});
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (del_upd) begin
               if (q_upd.size() == 0) miss("upd_extra", 32'(del_out));
               else begin
                  e = q_upd.pop_front();
                  chk("upd_del", 32'(del_out), 32'(e.v));
                  chk("upd_period", pcount, e.per);
               end
            end
            if (shot_valid) begin
               if (q_shot.size() == 0) miss("shot_extra", 32'(point_idx));
               else begin
                  e = q_shot.pop_front();
                  chk("shot_idx", 32'(point_idx), 32'(e.v));
                  chk("shot_period", pcount, e.per);
               end
            end
            if (done) begin
               if (q_done.size() == 0) miss("done_extra", 32'(del_out));
               else begin
                  e = q_done.pop_front();
                  chk("done_del", 32'(del_out), 32'(e.v));
                  chk("done_err", 32'(err_ovf), 32'(e.e));
                  chk("done_period", pcount, e.per);
               end
            end
         end
      end
   end
   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1);
   end
   initial begin
      repeat (2) tick();
      chk("rst_cfg_ready", 32'(cfg_ready), 1);
      chk("rst_del_out", 32'(del_out), 0);
      chk("rst_point_idx", 32'(point_idx), 0);
      chk("rst_flags", 32'({del_upd, shot_valid, busy, done, err_ovf}), 0);
      reset = 1'b0;
      tick();
      // full three-point scan
      cfg(16'd100, 16'd50, 16'd3, 16'd4);
      pcount = 0;
      sched_scan1();
      pulse_start();
      chk("s1_busy", 32'(busy), 1);
      chk("s1_cfg_ready_busy", 32'(cfg_ready), 0);
      run_periods(15);
      wait_done("s1_done_seen", 10);
      chk("s1_busy_end", 32'(busy), 0);
      tick();
      chk_empty("s1");
      // zero points, then zero shots: done two cycles after start, nothing else
      cfg(16'd1, 16'd1, 16'd0, 16'd5);
      pcount = 0;
      q_done.push_back('{16'd200, 1'b0, 0});
      pulse_start();
      chk("s2a_done_early", 32'(done), 0);
      tick();
      chk("s2a_done", 32'(done), 1);
      tick();
      cfg(16'd1, 16'd1, 16'd5, 16'd0);
      q_done.push_back('{16'd200, 1'b0, 0});
      pulse_start();
      chk("s2b_done_early", 32'(done), 0);
      tick();
      chk("s2b_done", 32'(done), 1);
      chk("s2b_busy", 32'(busy), 0);
      tick();
      chk_empty("s2");
      // delay overflow on the first step
      cfg(16'hFFF0, 16'h0020, 16'd2, 16'd1);
      pcount = 0;
      q_upd.push_back('{16'hFFF0, 1'b0, 0});
      q_shot.push_back('{16'd0, 1'b0, 2});
      q_done.push_back('{16'hFFF0, 1'b1, 2});
      pulse_start();
      run_periods(2);
      wait_done("s3_done_seen", 10);
      tick();
      chk("s3_err_sticky", 32'(err_ovf), 1);
      chk("s3_del_hold", 32'(del_out), 32'h0000FFF0);
      chk_empty("s3");
      // abort coincident with a shot strobe
      cfg(16'd10, 16'd1, 16'd3, 16'd4);
      chk("s4_err_cleared", 32'(err_ovf), 0);
      pcount = 0;
      q_upd.push_back('{16'd10, 1'b0, 0});
      q_shot.push_back('{16'd0, 1'b0, 2});
      q_shot.push_back('{16'd0, 1'b0, 3});
      q_done.push_back('{16'd10, 1'b0, 4});
      pulse_start();
      run_periods(3);
      repeat (19) tick();
      period_start = 1'b1;
      abort = 1'b1;
      pcount++;
      tick();
      period_start = 1'b0;
      abort = 1'b0;
      chk("s4_shot_on_abort", 32'(shot_valid), 0);
      chk("s4_done_early", 32'(done), 0);
      tick();
      chk("s4_done", 32'(done), 1);
      tick();
      chk("s4_cfg_ready", 32'(cfg_ready), 1);
      chk("s4_busy", 32'(busy), 0);
      run_periods(2);
      chk_empty("s4");
      // asynchronous reset while settling on the second point
      cfg(16'd500, 16'd1, 16'd3, 16'd1);
      pcount = 0;
      q_upd.push_back('{16'd500, 1'b0, 0});
      q_shot.push_back('{16'd0, 1'b0, 2});
      q_upd.push_back('{16'd501, 1'b0, 2});
      pulse_start();
      run_periods(2);
      repeat (3) tick();
      chk("s5_idx_before", 32'(point_idx), 1);
      chk("s5_del_before", 32'(del_out), 501);
      #3 reset = 1'b1;
      #1;
      chk("s5_del_out", 32'(del_out), 0);
      chk("s5_busy", 32'(busy), 0);
      chk("s5_point_idx", 32'(point_idx), 0);
      chk("s5_cfg_ready", 32'(cfg_ready), 1);
      tick();
      reset = 1'b0;
      tick();
      chk_empty("s5");
      // configuration ignored mid-scan, accepted afterwards
      cfg(16'd100, 16'd50, 16'd3, 16'd4);
      pcount = 0;
      sched_scan1();
      pulse_start();
      run_periods(3);
      cfg(16'd7, 16'd9, 16'd5, 16'd1);
      run_periods(12);
      wait_done("s6_done_seen", 10);
      tick();
      cfg(16'd7, 16'd9, 16'd5, 16'd1);
      pcount = 0;
      q_upd.push_back('{16'd7, 1'b0, 0});
      q_done.push_back('{16'd7, 1'b0, 0});
      pulse_start();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_done("s6_abort_done_seen", 10);
      tick();
      chk_empty("s6");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
